// File: rtl/flit_stim_gen.sv
// Flit traffic generator: emits num_pkts packets of payload_len flits
// separated by gap_len idle cycles, over a valid/ready link. Each 2N-bit
// flit is presented as two N-bit operands. Also counts the switching
// activity between consecutive transferred flits.
module flit_stim_gen #(
    parameter int unsigned N     = 11,
    parameter int unsigned RUN   = 6,
    parameter int unsigned SHIFT = 6,
    parameter logic [31:0] SEED  = 32'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [7:0]    payload_len,
    input  logic [7:0]    gap_len,
    input  logic [7:0]    num_pkts,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_a,
    output logic [N-1:0]  out_b,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [15:0]   flit_cnt,
    output logic [31:0]   toggle_cnt
);

    localparam int unsigned W         = 2 * N;
    localparam logic [31:0] SEED_NZ   = (SEED == '0) ? 32'd1 : SEED;
    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [W-1:0] ROT_INIT = {W{1'b1}} >> (W - RUN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        M_ROTATE = 2'd0,
        M_LFSR   = 2'd1,
        M_ALT    = 2'd2,
        M_ZERO   = 2'd3
    } mode_t;

    state_t        r_state;
    state_t        w_state_nx;
    mode_t         r_mode;
    logic [7:0]    r_payload;
    logic [7:0]    r_gap;
    logic [7:0]    r_pkts;
    logic [7:0]    r_beat;
    logic [7:0]    r_pkt;
    logic [7:0]    r_gap_cnt;
    logic [31:0]   r_lfsr;
    logic [W-1:0]  r_d;
    logic [W-1:0]  r_prev;
    logic [15:0]   r_flit_cnt;
    logic [31:0]   r_toggle_cnt;
    logic          r_done;

    logic          w_start_ok;
    logic          w_xfer;
    logic          w_last_beat;
    logic          w_last_pkt;
    logic [31:0]   w_lfsr_nx;
    logic [W-1:0]  w_d_nx;
    logic [W-1:0]  w_d_first;
    logic [5:0]    w_pop;
    logic [32:0]   w_tog_sum;

    function automatic logic [W-1:0] f_rotl(input logic [W-1:0] d);
        logic [2*W-1:0] dd;
        dd = {d, d} << SHIFT;
        return dd[2*W-1:W];
    endfunction

    // Pattern generation and switching-activity arithmetic
    always_comb begin
        w_start_ok  = (r_state == S_IDLE) && start;
        w_xfer      = (r_state == S_SEND) && out_ready;
        w_last_beat = (r_beat == (r_payload - 8'd1));
        w_last_pkt  = (r_pkt == (r_pkts - 8'd1));
        w_lfsr_nx   = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
        w_pop       = 6'($countones(r_d ^ r_prev));
        w_tog_sum   = {1'b0, r_toggle_cnt} + 33'(w_pop);

        w_d_nx = '0;
        case (r_mode)
            M_ROTATE: w_d_nx = f_rotl(r_d);
            M_LFSR:   w_d_nx = w_lfsr_nx[W-1:0];
            M_ALT:    w_d_nx = ~r_d;
            default:  w_d_nx = '0;
        endcase

        w_d_first = '0;
        case (mode_t'(mode))
            M_ROTATE: w_d_first = ROT_INIT;
            M_LFSR:   w_d_first = SEED_NZ[W-1:0];
            M_ALT:    w_d_first = '1;
            default:  w_d_first = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (payload_len == 8'd0 || num_pkts == 8'd0) w_state_nx = S_DONE;
                    else                                         w_state_nx = S_SEND;
                end
            end
            S_SEND: begin
                if (w_xfer && w_last_beat) begin
                    if (w_last_pkt)          w_state_nx = S_DONE;
                    else if (r_gap != 8'd0)  w_state_nx = S_GAP;
                    else                     w_state_nx = S_SEND;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 8'd1) w_state_nx = S_SEND;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // FSM outputs; flit fields come straight from the pattern register so
    // they stay stable for as long as the sink stalls
    always_comb begin
        out_valid  = (r_state == S_SEND);
        out_last   = (r_state == S_SEND) && w_last_beat;
        busy       = (r_state == S_SEND) || (r_state == S_GAP);
        done       = r_done;
        out_a      = r_d[N-1:0];
        out_b      = r_d[W-1:N];
        flit_cnt   = r_flit_cnt;
        toggle_cnt = r_toggle_cnt;
    end

    // Config latch, packet/gap counters, pattern and activity registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= M_ROTATE;
            r_payload    <= '0;
            r_gap        <= '0;
            r_pkts       <= '0;
            r_beat       <= '0;
            r_pkt        <= '0;
            r_gap_cnt    <= '0;
            r_lfsr       <= SEED_NZ;
            r_d          <= '0;
            r_prev       <= '0;
            r_flit_cnt   <= '0;
            r_toggle_cnt <= '0;
            r_done       <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_mode       <= mode_t'(mode);
                r_payload    <= payload_len;
                r_gap        <= gap_len;
                r_pkts       <= num_pkts;
                r_beat       <= '0;
                r_pkt        <= '0;
                r_gap_cnt    <= '0;
                r_lfsr       <= SEED_NZ;
                r_d          <= w_d_first;
                r_prev       <= '0;
                r_flit_cnt   <= '0;
                r_toggle_cnt <= '0;
                r_done       <= 1'b0;
            end

            if (w_xfer) begin
                r_flit_cnt   <= r_flit_cnt + 16'd1;
                r_toggle_cnt <= w_tog_sum[32] ? '1 : w_tog_sum[31:0];
                r_prev       <= r_d;
                r_d          <= w_d_nx;
                if (r_mode == M_LFSR) r_lfsr <= w_lfsr_nx;
                if (w_last_beat) begin
                    r_beat    <= '0;
                    r_pkt     <= r_pkt + 8'd1;
                    r_gap_cnt <= r_gap;
                end else begin
                    r_beat <= r_beat + 8'd1;
                end
            end

            if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt - 8'd1;

            // done is raised on entry to DONE so it is visible in that cycle
            if (w_state_nx == S_DONE && r_state != S_DONE) r_done <= 1'b1;
        end
    end

endmodule
